// File: rtl/ahb_arbiter_n.sv
// N-master AHB-Lite arbiter and master-side mux: fixed-priority or round-robin
// grant, burst-aware locking, address/data-phase owner tracking, default parking.
module ahb_arbiter_n #(
  parameter int NUM_MASTERS    = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ARB_MODE       = 1,
  parameter int DEFAULT_MASTER = 0
) (
  input  logic                              HCLK,
  input  logic                              rst,
  input  logic [NUM_MASTERS-1:0]            req,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] HADDR_M,
  input  logic [NUM_MASTERS-1:0]            HWRITE_M,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] HWDATA_M,
  input  logic [NUM_MASTERS*2-1:0]          HTRANS_M,
  input  logic [NUM_MASTERS*3-1:0]          HSIZE_M,
  input  logic [NUM_MASTERS*4-1:0]          HPROT_M,
  input  logic [NUM_MASTERS*3-1:0]          HBURST_M,
  output logic [DATA_WIDTH-1:0]             HRDATA_M,
  output logic [NUM_MASTERS-1:0]            HREADY_M,
  output logic [NUM_MASTERS-1:0]            HRESP_M,
  output logic [NUM_MASTERS-1:0]            HGRANT,
  output logic [ADDR_WIDTH-1:0]             HADDR_OUT,
  output logic                              HWRITE_OUT,
  output logic [1:0]                        HTRANS_OUT,
  output logic [2:0]                        HSIZE_OUT,
  output logic [3:0]                        HPROT_OUT,
  output logic [2:0]                        HBURST_OUT,
  output logic [DATA_WIDTH-1:0]             HWDATA_OUT,
  input  logic [DATA_WIDTH-1:0]             HRDATA_IN,
  input  logic                              HREADY_IN,
  input  logic                              HRESP_IN
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IW-1:0] DEF_IDX = IW'(DEFAULT_MASTER);

  typedef enum logic [1:0] {
    TR_IDLE   = 2'b00,
    TR_BUSY   = 2'b01,
    TR_NONSEQ = 2'b10,
    TR_SEQ    = 2'b11
  } htrans_e;

  logic [IW-1:0] r_addr_idx;
  logic [IW-1:0] r_data_idx;
  logic [IW-1:0] r_rr_ptr;
  logic [4:0]    r_beats_left;
  logic          r_incr_lock;

  logic [1:0]    w_own_trans;
  logic [2:0]    w_own_burst;
  logic          w_own_req;
  logic          w_locked;
  logic [4:0]    w_burst_beats;
  logic [4:0]    w_beats_nxt;
  logic          w_incr_nxt;
  logic          w_locked_nxt;
  logic          w_any_req;
  logic [IW-1:0] w_fp_win;
  logic [IW-1:0] w_rr_win;
  logic [IW-1:0] w_win;

  assign w_own_trans = HTRANS_M[r_addr_idx*2 +: 2];
  assign w_own_burst = HBURST_M[r_addr_idx*3 +: 3];
  assign w_own_req   = req[r_addr_idx];
  assign w_locked    = (r_beats_left != 5'd0) || r_incr_lock;
  assign w_any_req   = |req;

  assign HADDR_OUT  = HADDR_M[r_addr_idx*ADDR_WIDTH +: ADDR_WIDTH];
  assign HWRITE_OUT = HWRITE_M[r_addr_idx];
  assign HSIZE_OUT  = HSIZE_M[r_addr_idx*3 +: 3];
  assign HPROT_OUT  = HPROT_M[r_addr_idx*4 +: 4];
  assign HBURST_OUT = w_own_burst;
  // A parked or withdrawn owner must not leak a stale transfer onto the bus.
  assign HTRANS_OUT = (w_own_req || w_locked) ? w_own_trans : TR_IDLE;
  assign HWDATA_OUT = HWDATA_M[r_data_idx*DATA_WIDTH +: DATA_WIDTH];
  assign HRDATA_M   = HRDATA_IN;

  always_comb begin
    HGRANT = '0;
    HGRANT[r_addr_idx] = 1'b1;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      HREADY_M[i] = ((r_data_idx == IW'(i)) || (r_addr_idx == IW'(i))) ? HREADY_IN : 1'b0;
      HRESP_M[i]  = (r_data_idx == IW'(i)) ? HRESP_IN : 1'b0;
    end
  end

  always_comb begin
    case (w_own_burst)
      3'd2, 3'd3: w_burst_beats = 5'd3;
      3'd4, 3'd5: w_burst_beats = 5'd7;
      3'd6, 3'd7: w_burst_beats = 5'd15;
      default:    w_burst_beats = 5'd0;
    endcase
  end

  always_comb begin
    w_beats_nxt = r_beats_left;
    w_incr_nxt  = r_incr_lock;
    if (HRESP_IN) begin
      w_beats_nxt = 5'd0;
      w_incr_nxt  = 1'b0;
    end else begin
      case (HTRANS_OUT)
        TR_NONSEQ: begin
          w_beats_nxt = w_burst_beats;
          w_incr_nxt  = (w_own_burst == 3'd1);
        end
        TR_SEQ: begin
          if (r_beats_left != 5'd0) w_beats_nxt = r_beats_left - 5'd1;
        end
        TR_IDLE: w_incr_nxt = 1'b0;
        default: ;
      endcase
      if (!w_own_req) w_incr_nxt = 1'b0;
    end
    w_locked_nxt = (w_beats_nxt != 5'd0) || w_incr_nxt;
  end

  // Scan from the far end so the nearest candidate is the last one written.
  always_comb begin
    int c;
    w_fp_win = DEF_IDX;
    w_rr_win = DEF_IDX;
    c = 0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (req[i]) w_fp_win = IW'(i);
    end
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      c = (int'(r_rr_ptr) + k) % NUM_MASTERS;
      if (req[c]) w_rr_win = IW'(c);
    end
    if (!w_any_req)         w_win = DEF_IDX;
    else if (ARB_MODE == 0) w_win = w_fp_win;
    else                    w_win = w_rr_win;
  end

  always_ff @(posedge HCLK) begin
    if (rst) begin
      r_addr_idx   <= DEF_IDX;
      r_data_idx   <= DEF_IDX;
      r_rr_ptr     <= DEF_IDX;
      r_beats_left <= 5'd0;
      r_incr_lock  <= 1'b0;
    end else if (HREADY_IN) begin
      r_data_idx   <= r_addr_idx;
      r_beats_left <= w_beats_nxt;
      r_incr_lock  <= w_incr_nxt;
      if (!w_locked_nxt) begin
        r_addr_idx <= w_win;
        if (w_any_req) r_rr_ptr <= w_win;
      end
    end
  end

endmodule

// File: tb/tb_ahb_arbiter_n.sv
// Bench for ahb_arbiter_n: fixed-priority and round-robin instances share
// stimulus and are compared against a transfer-level reference model.
module tb_ahb_arbiter_n;

  logic         HCLK = 1'b0;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] haddr;
  logic [3:0]   hwrite;
  logic [127:0] hwdata;
  logic [7:0]   htrans;
  logic [11:0]  hsize;
  logic [15:0]  hprot;
  logic [11:0]  hburst;
  logic [31:0]  hrdata_in;
  logic         hready_in;
  logic         hresp_in;

  logic [31:0] o_hrdata [2];
  logic [3:0]  o_hready [2];
  logic [3:0]  o_hresp  [2];
  logic [3:0]  o_grant  [2];
  logic [31:0] o_haddr  [2];
  logic        o_hwrite [2];
  logic [1:0]  o_htrans [2];
  logic [2:0]  o_hsize  [2];
  logic [3:0]  o_hprot  [2];
  logic [2:0]  o_hburst [2];
  logic [31:0] o_hwdata [2];

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state, index 0 = fixed priority, 1 = round robin
  int m_grant [2];
  int m_down  [2];
  int m_rr    [2];
  int m_beats [2];
  bit m_incr  [2];

  always #5 HCLK = ~HCLK;

  ahb_arbiter_n #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                  .ARB_MODE(0), .DEFAULT_MASTER(0)) u_fp (
    .HCLK(HCLK), .rst(rst), .req(req),
    .HADDR_M(haddr), .HWRITE_M(hwrite), .HWDATA_M(hwdata), .HTRANS_M(htrans),
    .HSIZE_M(hsize), .HPROT_M(hprot), .HBURST_M(hburst),
    .HRDATA_M(o_hrdata[0]), .HREADY_M(o_hready[0]), .HRESP_M(o_hresp[0]),
    .HGRANT(o_grant[0]), .HADDR_OUT(o_haddr[0]), .HWRITE_OUT(o_hwrite[0]),
    .HTRANS_OUT(o_htrans[0]), .HSIZE_OUT(o_hsize[0]), .HPROT_OUT(o_hprot[0]),
    .HBURST_OUT(o_hburst[0]), .HWDATA_OUT(o_hwdata[0]),
    .HRDATA_IN(hrdata_in), .HREADY_IN(hready_in), .HRESP_IN(hresp_in));

  ahb_arbiter_n #(.NUM_MASTERS(4), .ADDR_WIDTH(32), .DATA_WIDTH(32),
                  .ARB_MODE(1), .DEFAULT_MASTER(0)) u_rr (
    .HCLK(HCLK), .rst(rst), .req(req),
    .HADDR_M(haddr), .HWRITE_M(hwrite), .HWDATA_M(hwdata), .HTRANS_M(htrans),
    .HSIZE_M(hsize), .HPROT_M(hprot), .HBURST_M(hburst),
    .HRDATA_M(o_hrdata[1]), .HREADY_M(o_hready[1]), .HRESP_M(o_hresp[1]),
    .HGRANT(o_grant[1]), .HADDR_OUT(o_haddr[1]), .HWRITE_OUT(o_hwrite[1]),
    .HTRANS_OUT(o_htrans[1]), .HSIZE_OUT(o_hsize[1]), .HPROT_OUT(o_hprot[1]),
    .HBURST_OUT(o_hburst[1]), .HWDATA_OUT(o_hwdata[1]),
    .HRDATA_IN(hrdata_in), .HREADY_IN(hready_in), .HRESP_IN(hresp_in));

  function automatic int burst_len(int b);
    // WRAP4/INCR4 -> 4 beats, WRAP8/INCR8 -> 8, WRAP16/INCR16 -> 16; remaining after first
    if (b < 2) return 0;
    return (4 << ((b - 2) / 2)) - 1;
  endfunction

  function automatic logic [1:0] exp_trans(int md);
    int own;
    own = m_grant[md];
    if (req[own] || m_beats[md] != 0 || m_incr[md]) return htrans[own*2 +: 2];
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int md = 0; md < 2; md++) begin
      m_grant[md] = 0; m_down[md] = 0; m_rr[md] = 0; m_beats[md] = 0; m_incr[md] = 0;
    end
  endtask

  task automatic model_step();
    int own, t, b, w, c;
    for (int md = 0; md < 2; md++) begin
      if (rst) begin
        m_grant[md] = 0; m_down[md] = 0; m_rr[md] = 0; m_beats[md] = 0; m_incr[md] = 0;
      end else if (hready_in) begin
        own = m_grant[md];
        t   = int'(exp_trans(md));
        b   = int'(hburst[own*3 +: 3]);
        if (hresp_in) begin
          m_beats[md] = 0; m_incr[md] = 0;
        end else begin
          if (t == 2) begin
            m_beats[md] = burst_len(b); m_incr[md] = (b == 1);
          end else if (t == 3 && m_beats[md] > 0) begin
            m_beats[md] = m_beats[md] - 1;
          end else if (t == 0) begin
            m_incr[md] = 0;
          end
          if (!req[own]) m_incr[md] = 0;
        end
        m_down[md] = own;
        if (m_beats[md] == 0 && !m_incr[md]) begin
          w = -1;
          for (int k = 1; k <= 4; k++) begin
            c = (md == 0) ? k - 1 : (m_rr[md] + k) % 4;
            if (w < 0 && req[c]) w = c;
          end
          if (w < 0) m_grant[md] = 0;
          else begin
            m_grant[md] = w; m_rr[md] = w;
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    model_step();
    #1;
  endtask

  task automatic set_m(int i, logic [1:0] t, logic [2:0] b, logic w,
                       logic [31:0] a, logic [31:0] d);
    htrans[i*2 +: 2]  = t;
    hburst[i*3 +: 3]  = b;
    hwrite[i]         = w;
    haddr[i*32 +: 32] = a;
    hwdata[i*32 +: 32] = d;
    hsize[i*3 +: 3]   = 3'd2;
    hprot[i*4 +: 4]   = 4'h3;
  endtask

  task automatic idle_all();
    req = '0; htrans = '0; hburst = '0; hwrite = '0; hsize = '0; hprot = '0;
    haddr = '0; hwdata = '0; hrdata_in = '0; hready_in = 1'b1; hresp_in = 1'b0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    set_m(0, 2'b10, 3'd0, 1'b1, 32'h0000_0100, 32'h0);
    @(negedge HCLK);
    for (int md = 0; md < 2; md++) begin
      n_checks++;
      if (o_grant[md] !== 4'b0001) begin
        n_fail++; $display("FAIL reset_grant md=%0d got %b expected 0001", md, o_grant[md]);
      end
      n_checks++;
      if (o_htrans[md] !== 2'b00) begin
        n_fail++; $display("FAIL reset_htrans md=%0d got %b expected 00", md, o_htrans[md]);
      end
      n_checks++;
      if (o_hready[md] !== 4'b0001) begin
        n_fail++; $display("FAIL reset_hready_hi md=%0d got %b expected 0001", md, o_hready[md]);
      end
    end
    hready_in = 1'b0;
    #1;
    for (int md = 0; md < 2; md++) begin
      n_checks++;
      if (o_hready[md] !== 4'b0000) begin
        n_fail++; $display("FAIL reset_hready_lo md=%0d got %b expected 0000", md, o_hready[md]);
      end
    end
    hready_in = 1'b1;
    set_m(0, 2'b00, 3'd0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_fixed_priority();
    do_reset();
    req = 4'b1010;
    set_m(1, 2'b10, 3'd0, 1'b0, 32'h1000_0010, 32'h0);
    set_m(3, 2'b10, 3'd0, 1'b0, 32'h3000_0030, 32'h0);
    for (int k = 0; k < 8; k++) begin
      tick();
      @(negedge HCLK);
      n_checks++;
      if (o_grant[0] !== 4'b0010) begin
        n_fail++; $display("FAIL fp_grant cyc=%0d got %b expected 0010", k, o_grant[0]);
      end
      n_checks++;
      if (o_haddr[0] !== 32'h1000_0010 || o_htrans[0] !== 2'b10) begin
        n_fail++; $display("FAIL fp_addr cyc=%0d got %h/%b expected 10000010/10", k, o_haddr[0], o_htrans[0]);
      end
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 4; i++) set_m(i, 2'b10, 3'd0, 1'b0, 32'hA000_0000 + i, 32'h0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      @(negedge HCLK);
      eg = '0;
      eg[k % 4] = 1'b1;
      n_checks++;
      if (o_grant[1] !== eg) begin
        n_fail++; $display("FAIL rr_grant step=%0d got %b expected %b", k, o_grant[1], eg);
      end
      n_checks++;
      if (o_haddr[1] !== 32'hA000_0000 + (k % 4)) begin
        n_fail++; $display("FAIL rr_addr step=%0d got %h expected %h", k, o_haddr[1], 32'hA000_0000 + (k % 4));
      end
    end
  endtask

  task automatic test_burst_lock();
    int  acc, cyc;
    bit  hr;
    do_reset();
    req = 4'b0100;
    tick();
    set_m(2, 2'b10, 3'd5, 1'b1, 32'h2000_0000, 32'h2222_0000);
    set_m(0, 2'b10, 3'd0, 1'b0, 32'h0000_0400, 32'h0);
    req = 4'b0101;
    acc = 0; cyc = 0; hr = 1'b1;
    while (acc < 8 && cyc < 40) begin
      hready_in = hr;
      @(negedge HCLK);
      for (int md = 0; md < 2; md++) begin
        n_checks++;
        if (o_grant[md] !== 4'b0100) begin
          n_fail++; $display("FAIL burst_hold md=%0d beat=%0d got %b expected 0100", md, acc, o_grant[md]);
        end
        n_checks++;
        if (o_htrans[md] !== exp_trans(md)) begin
          n_fail++; $display("FAIL burst_htrans md=%0d beat=%0d got %b expected %b", md, acc, o_htrans[md], exp_trans(md));
        end
      end
      tick();
      if (hr) begin
        acc++;
        htrans[5:4] = 2'b11;
      end
      hr = !hr;
      cyc++;
    end
    n_checks++;
    if (acc != 8) begin
      n_fail++; $display("FAIL burst_timeout got %0d beats expected 8", acc);
    end
    htrans[5:4] = 2'b00;
    hready_in = 1'b1;
    @(negedge HCLK);
    for (int md = 0; md < 2; md++) begin
      n_checks++;
      if (o_grant[md] !== 4'b0001) begin
        n_fail++; $display("FAIL burst_release md=%0d got %b expected 0001", md, o_grant[md]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    req = 4'b0010;
    set_m(1, 2'b10, 3'd0, 1'b1, 32'h1000_0000, 32'h1111_AAAA);
    tick();
    req = 4'b1010;
    set_m(3, 2'b10, 3'd0, 1'b1, 32'h3000_0000, 32'h3333_5555);
    @(negedge HCLK);
    n_checks++;
    if (o_grant[1] !== 4'b0010) begin
      n_fail++; $display("FAIL b2b_first_grant got %b expected 0010", o_grant[1]);
    end
    tick();
    htrans[3:2] = 2'b00;
    req = 4'b1000;
    hready_in = 1'b0;
    hresp_in = 1'b1;
    for (int s = 0; s < 2; s++) begin
      @(negedge HCLK);
      n_checks++;
      if (o_hwdata[1] !== 32'h1111_AAAA) begin
        n_fail++; $display("FAIL b2b_stall_wdata cyc=%0d got %h expected 1111aaaa", s, o_hwdata[1]);
      end
      n_checks++;
      if (o_hresp[1] !== 4'b0010 || o_hready[1] !== 4'b0000 || o_grant[1] !== 4'b1000) begin
        n_fail++; $display("FAIL b2b_stall_resp cyc=%0d got resp %b ready %b grant %b expected 0010/0000/1000",
                           s, o_hresp[1], o_hready[1], o_grant[1]);
      end
      tick();
    end
    hready_in = 1'b1;
    hresp_in = 1'b0;
    @(negedge HCLK);
    n_checks++;
    if (o_hwdata[1] !== 32'h1111_AAAA || o_hready[1] !== 4'b1010) begin
      n_fail++; $display("FAIL b2b_release got %h/%b expected 1111aaaa/1010", o_hwdata[1], o_hready[1]);
    end
    tick();
    htrans[7:6] = 2'b00;
    hresp_in = 1'b1;
    @(negedge HCLK);
    n_checks++;
    if (o_hwdata[1] !== 32'h3333_5555) begin
      n_fail++; $display("FAIL b2b_second_wdata got %h expected 33335555", o_hwdata[1]);
    end
    n_checks++;
    if (o_hresp[1] !== 4'b1000 || o_hready[1] !== 4'b1000) begin
      n_fail++; $display("FAIL b2b_second_resp got %b/%b expected 1000/1000", o_hresp[1], o_hready[1]);
    end
    hresp_in = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b0100;
    tick();
    set_m(2, 2'b10, 3'd3, 1'b1, 32'h2000_0000, 32'h0);
    req = 4'b0101;
    tick();
    htrans[5:4] = 2'b11;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge HCLK);
    for (int md = 0; md < 2; md++) begin
      n_checks++;
      if (o_grant[md] !== 4'b0001 || o_htrans[md] !== 2'b00) begin
        n_fail++; $display("FAIL midrst_state md=%0d got %b/%b expected 0001/00", md, o_grant[md], o_htrans[md]);
      end
    end
    tick();
    @(negedge HCLK);
    n_checks++;
    if (o_grant[1] !== 4'b0100 || o_grant[0] !== 4'b0001) begin
      n_fail++; $display("FAIL midrst_nolock got rr %b fp %b expected 0100/0001", o_grant[1], o_grant[0]);
    end
  endtask

  task automatic test_random();
    logic [3:0] eg, er, ers;
    int own, dn;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst       = ($urandom_range(63) == 0);
      req       = 4'($urandom);
      hready_in = ($urandom_range(3) != 0);
      hresp_in  = ($urandom_range(15) == 0);
      hrdata_in = $urandom;
      for (int i = 0; i < 4; i++)
        set_m(i, ($urandom_range(2) == 0) ? 2'($urandom) : 2'b11, 3'($urandom),
              1'($urandom), $urandom, $urandom);
      @(negedge HCLK);
      for (int md = 0; md < 2; md++) begin
        own = m_grant[md];
        dn  = m_down[md];
        eg = '0; eg[own] = 1'b1;
        er = '0; ers = '0;
        for (int i = 0; i < 4; i++) begin
          if (i == own || i == dn) er[i] = hready_in;
          if (i == dn) ers[i] = hresp_in;
        end
        n_checks++;
        if (o_grant[md] !== eg) begin
          n_fail++; $display("FAIL rnd_grant md=%0d cyc=%0d got %b expected %b", md, cyc, o_grant[md], eg);
        end
        n_checks++;
        if (o_htrans[md] !== exp_trans(md)) begin
          n_fail++; $display("FAIL rnd_htrans md=%0d cyc=%0d got %b expected %b", md, cyc, o_htrans[md], exp_trans(md));
        end
        n_checks++;
        if (o_haddr[md] !== haddr[own*32 +: 32] || o_hwrite[md] !== hwrite[own] ||
            o_hsize[md] !== hsize[own*3 +: 3] || o_hprot[md] !== hprot[own*4 +: 4] ||
            o_hburst[md] !== hburst[own*3 +: 3]) begin
          n_fail++; $display("FAIL rnd_addr_mux md=%0d cyc=%0d got %h expected %h (owner %0d)",
                             md, cyc, o_haddr[md], haddr[own*32 +: 32], own);
        end
        n_checks++;
        if (o_hwdata[md] !== hwdata[dn*32 +: 32]) begin
          n_fail++; $display("FAIL rnd_hwdata md=%0d cyc=%0d got %h expected %h", md, cyc, o_hwdata[md], hwdata[dn*32 +: 32]);
        end
        n_checks++;
        if (o_hready[md] !== er || o_hresp[md] !== ers || o_hrdata[md] !== hrdata_in) begin
          n_fail++; $display("FAIL rnd_resp md=%0d cyc=%0d got %b/%b expected %b/%b", md, cyc,
                             o_hready[md], o_hresp[md], er, ers);
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle_all();
    model_reset();
    test_reset();
    test_fixed_priority();
    test_round_robin();
    test_burst_lock();
    test_back_to_back();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout simulation did not reach the end of the test sequence");
    $fatal(1, "timeout");
  end

endmodule
